fetch_sequencer: RTL and testbench

//  Instruction-fetch controller that sequences the program counter.

---
 rtl/fetch_seq_pkg.sv | 5 +
 rtl/wait_timer.sv | 20 ++
 rtl/fetch_sequencer.sv | 126 ++++++++++++
 tb/tb_fetch_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_seq_pkg.sv
// fetch_seq_pkg: shared state encoding and constants for the fetch sequencer
package fetch_seq_pkg;
    typedef enum logic [1:0] {IDLE, REQ, HOLD, FAULT} fetch_state_t;
    localparam int PC_INCR = 1;
endpackage

// File: rtl/wait_timer.sv
// wait_timer: saturating counter of unacknowledged request cycles
module wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic n_rst,
    input  logic in_clear,
    input  logic in_count,
    output logic out_expired
);
    localparam int CW = $clog2(MAX_WAIT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb cnt_d = in_clear ? '0 : (in_count && cnt_q != CW'(MAX_WAIT)) ? cnt_q + CW'(1) : cnt_q;
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
    // asserted in the cycle whose edge brings the count to MAX_WAIT
    assign out_expired = cnt_d == CW'(MAX_WAIT);
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC sequencing, one memory read per instruction, valid/ready to decode
module fetch_sequencer
    import fetch_seq_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               MAX_WAIT     = 15
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             in_run,
    input  logic             in_branch_valid,
    input  logic [WIDTH-1:0] in_branch_target,
    output logic             out_mem_req,
    output logic [WIDTH-1:0] out_mem_addr,
    input  logic             in_mem_ack,
    input  logic [WIDTH-1:0] in_mem_data,
    output logic             out_instr_valid,
    output logic [WIDTH-1:0] out_instr,
    output logic [WIDTH-1:0] out_instr_pc,
    input  logic             in_instr_ready,
    output logic [WIDTH-1:0] out_pc,
    output logic             out_fault
);
    fetch_state_t state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d, addr_q, addr_d, instr_q, instr_d, ipc_q, ipc_d;
    logic req_q, req_d, valid_q, valid_d, fault_q, fault_d, discard_q, discard_d;
    logic expired;

    wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
        .clk         (clk),
        .n_rst       (n_rst),
        .in_clear    (state_q != REQ || in_mem_ack),
        .in_count    (state_q == REQ && !in_mem_ack),
        .out_expired (expired)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        addr_d    = addr_q;
        req_d     = req_q;
        instr_d   = instr_q;
        ipc_d     = ipc_q;
        valid_d   = valid_q;
        fault_d   = fault_q;
        discard_d = discard_q;
        case (state_q)
            IDLE: begin
                pc_d = in_branch_valid ? in_branch_target : pc_q;
                if (in_run) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    addr_d  = pc_d;
                end
            end
            REQ: begin
                if (in_mem_ack && (discard_q || in_branch_valid)) begin
                    // a redirected fetch's data is dropped and the target is fetched next
                    discard_d = 1'b0;
                    pc_d      = in_branch_valid ? in_branch_target : pc_q;
                    state_d   = in_run ? REQ : IDLE;
                    req_d     = in_run;
                    addr_d    = pc_d;
                end else if (in_mem_ack) begin
                    req_d   = 1'b0;
                    instr_d = in_mem_data;
                    ipc_d   = addr_q;
                    pc_d    = pc_q + WIDTH'(PC_INCR);
                    valid_d = 1'b1;
                    state_d = HOLD;
                end else if (expired) begin
                    state_d   = FAULT;
                    req_d     = 1'b0;
                    fault_d   = 1'b1;
                    discard_d = 1'b0;
                end else if (in_branch_valid) begin
                    pc_d      = in_branch_target;
                    discard_d = 1'b1;
                end
            end
            HOLD: begin
                if (in_instr_ready || in_branch_valid) begin
                    valid_d = 1'b0;
                    pc_d    = in_branch_valid ? in_branch_target : pc_q;
                    state_d = in_run ? REQ : IDLE;
                    req_d   = in_run;
                    addr_d  = pc_d;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            pc_q      <= RESET_VECTOR;
            addr_q    <= '0;
            req_q     <= 1'b0;
            instr_q   <= '0;
            ipc_q     <= '0;
            valid_q   <= 1'b0;
            fault_q   <= 1'b0;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            addr_q    <= addr_d;
            req_q     <= req_d;
            instr_q   <= instr_d;
            ipc_q     <= ipc_d;
            valid_q   <= valid_d;
            fault_q   <= fault_d;
            discard_q <= discard_d;
        end
    end

    assign out_mem_req     = req_q;
    assign out_mem_addr    = addr_q;
    assign out_instr_valid = valid_q;
    assign out_instr       = instr_q;
    assign out_instr_pc    = ipc_q;
    assign out_pc          = pc_q;
    assign out_fault       = fault_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed stimulus with a memory responder and a scoreboard monitor
module tb_fetch_sequencer;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        run = 1'b0, br = 1'b0, ready = 1'b1;
    logic [31:0] tgt = '0;
    logic        mem_req, mem_ack, valid, fault;
    logic [31:0] mem_addr, mem_data, instr, ipc, pc;
    logic        w_run = 1'b0, w_ack = 1'b0, w_req, w_valid, w_fault;
    logic [31:0] w_data = '0, w_addr, w_instr, w_ipc, w_pc;
    logic        ack_en = 1'b1, stray = 1'b0;
    int          lat = 1;
    logic [31:0] force_addr = 32'hFFFF_FFFF;
    exp_t        sb[$];
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    fetch_sequencer #(.WIDTH(32), .RESET_VECTOR(32'h0), .MAX_WAIT(15)) dut (
        .clk(clk), .n_rst(n_rst), .in_run(run), .in_branch_valid(br), .in_branch_target(tgt),
        .out_mem_req(mem_req), .out_mem_addr(mem_addr), .in_mem_ack(mem_ack), .in_mem_data(mem_data),
        .out_instr_valid(valid), .out_instr(instr), .out_instr_pc(ipc), .in_instr_ready(ready),
        .out_pc(pc), .out_fault(fault)
    );

    fetch_sequencer #(.WIDTH(32), .RESET_VECTOR(32'hFFFF_FFFF), .MAX_WAIT(15)) dut_wrap (
        .clk(clk), .n_rst(n_rst), .in_run(w_run), .in_branch_valid(1'b0), .in_branch_target(32'h0),
        .out_mem_req(w_req), .out_mem_addr(w_addr), .in_mem_ack(w_ack), .in_mem_data(w_data),
        .out_instr_valid(w_valid), .out_instr(w_instr), .out_instr_pc(w_ipc), .in_instr_ready(1'b1),
        .out_pc(w_pc), .out_fault(w_fault)
    );

    function automatic logic [31:0] dat(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] a);
        sb.push_back('{a, dat(a)});
    endtask

    task automatic wait_valid_pc(input logic [31:0] p);
        bit hit = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            @(negedge clk);
            hit = valid && ipc == p;
        end
        check($sformatf("wait_valid_pc_%0h", p), {31'b0, hit}, 32'd1);
    endtask

    // memory: ack after lat request cycles, one cycle wide
    initial begin
        int cnt;
        cnt = 0;
        mem_ack = 1'b0;
        mem_data = '0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (stray) begin
                mem_ack = 1'b1;
                mem_data = 32'hBAD0_BAD0;
            end else if (!mem_req) cnt = 0;
            else if (ack_en) begin
                cnt++;
                if (cnt >= lat) begin
                    mem_ack = 1'b1;
                    mem_data = (mem_addr == force_addr) ? 32'h0000_DEAD : dat(mem_addr);
                    cnt = 0;
                end
            end
        end
    end

    // scoreboard monitor: every accepted instruction pops one expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (n_rst && valid && ready) begin
                if (sb.size() == 0) check("sb_unexpected_valid", {31'b0, valid}, 32'd0);
                else begin
                    e = sb.pop_front();
                    check("sb_instr_pc", ipc, e.pc);
                    check("sb_instr", instr, e.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("rst_pc", pc, 32'h0);
        check("rst_req", {31'b0, mem_req}, 32'd0);
        check("rst_valid", {31'b0, valid}, 32'd0);
        check("rst_fault", {31'b0, fault}, 32'd0);
        check("rst_instr_pc", ipc, 32'h0);
        check("rst_wrap_pc", w_pc, 32'hFFFF_FFFF);
        n_rst = 1'b1;
        // sequential fetch 0..3
        for (int i = 0; i < 4; i++) push(i);
        @(negedge clk);
        run = 1'b1;
        @(negedge clk);
        check("t1_req_rise", {31'b0, mem_req}, 32'd1);
        check("t1_req_addr", mem_addr, 32'h0);
        wait_valid_pc(32'h3);
        run = 1'b0;
        repeat (3) @(negedge clk);
        check("t1_pc", pc, 32'h4);
        check("t1_idle_req", {31'b0, mem_req}, 32'd0);
        // PC wrap from all-ones reset vector
        w_run = 1'b1;
        @(negedge clk);
        check("t2_req", {31'b0, w_req}, 32'd1);
        check("t2_addr", w_addr, 32'hFFFF_FFFF);
        w_ack = 1'b1;
        w_data = 32'h1234_5678;
        w_run = 1'b0;
        @(negedge clk);
        w_ack = 1'b0;
        check("t2_valid", {31'b0, w_valid}, 32'd1);
        check("t2_instr_pc", w_ipc, 32'hFFFF_FFFF);
        check("t2_instr", w_instr, 32'h1234_5678);
        check("t2_pc_wrap", w_pc, 32'h0);
        // decode stall
        ready = 1'b0;
        run = 1'b1;
        push(32'h4);
        wait_valid_pc(32'h4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_hold_valid", {31'b0, valid}, 32'd1);
            check("t3_hold_pc", ipc, 32'h4);
            check("t3_hold_instr", instr, dat(32'h4));
            check("t3_hold_noreq", {31'b0, mem_req}, 32'd0);
        end
        push(32'h5);
        ready = 1'b1;
        @(negedge clk);
        check("t3_next_req", {31'b0, mem_req}, 32'd1);
        check("t3_next_addr", mem_addr, 32'h5);
        run = 1'b0;
        wait_valid_pc(32'h5);
        repeat (3) @(negedge clk);
        check("t3_pc", pc, 32'h6);
        // branch during REQ discards the outstanding fetch
        lat = 2;
        force_addr = 32'h6;
        push(32'h100);
        run = 1'b1;
        @(negedge clk);
        check("t4_req_addr", mem_addr, 32'h6);
        br = 1'b1;
        tgt = 32'h100;
        @(negedge clk);
        br = 1'b0;
        check("t4_pc_redirect", pc, 32'h100);
        @(negedge clk);
        check("t4_refetch_req", {31'b0, mem_req}, 32'd1);
        check("t4_refetch_addr", mem_addr, 32'h100);
        check("t4_no_valid", {31'b0, valid}, 32'd0);
        run = 1'b0;
        wait_valid_pc(32'h100);
        repeat (3) @(negedge clk);
        check("t4_pc", pc, 32'h101);
        // branch in HOLD without ready flushes the instruction
        lat = 1;
        ready = 1'b0;
        run = 1'b1;
        wait_valid_pc(32'h101);
        br = 1'b1;
        tgt = 32'h40;
        @(negedge clk);
        br = 1'b0;
        check("t5_flush_valid", {31'b0, valid}, 32'd0);
        check("t5_req", {31'b0, mem_req}, 32'd1);
        check("t5_addr", mem_addr, 32'h40);
        push(32'h40);
        ready = 1'b1;
        run = 1'b0;
        wait_valid_pc(32'h40);
        repeat (3) @(negedge clk);
        check("t5_pc", pc, 32'h41);
        // memory never acknowledges
        ack_en = 1'b0;
        run = 1'b1;
        n = 0;
        for (int i = 0; i < 60 && !fault; i++) begin
            @(negedge clk);
            if (!fault && mem_req) n++;
        end
        check("t6_req_cycles", n, 32'd15);
        check("t6_fault", {31'b0, fault}, 32'd1);
        check("t6_fault_req", {31'b0, mem_req}, 32'd0);
        check("t6_fault_valid", {31'b0, valid}, 32'd0);
        br = 1'b1;
        tgt = 32'h10;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            run = ~run;
        end
        check("t6_fault_sticky", {31'b0, fault}, 32'd1);
        check("t6_fault_pc", pc, 32'h41);
        @(negedge clk);
        #3 n_rst = 1'b0;
        #1;
        check("t6_async_fault", {31'b0, fault}, 32'd0);
        check("t6_async_pc", pc, 32'h0);
        @(negedge clk);
        n_rst = 1'b1;
        br = 1'b0;
        run = 1'b0;
        ack_en = 1'b1;
        // reset mid-transaction, then a late ack
        lat = 3;
        run = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t7_req", {31'b0, mem_req}, 32'd1);
        #3 n_rst = 1'b0;
        #1;
        check("t7_rst_req", {31'b0, mem_req}, 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        run = 1'b0;
        stray = 1'b1;
        repeat (2) @(negedge clk);
        stray = 1'b0;
        repeat (3) @(negedge clk);
        check("t7_late_valid", {31'b0, valid}, 32'd0);
        check("t7_late_req", {31'b0, mem_req}, 32'd0);
        check("t7_late_pc", pc, 32'h0);
        check("sb_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
